// File: rtl/mem_arb_ctrl_if.sv
// Bus bundle for mem_arb_ctrl: Wishbone slave port, IO requester port and the
// synchronous single-port memory port. The arbiter side uses modport slave.
interface mem_arb_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    // Handshakes: a Wishbone cycle is cyc&stb held until the one-cycle ack;
    // an IO request is io_req held with stable operands until the one-cycle gnt,
    // read data follows one cycle after gnt with io_rvalid.
    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic              wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i;
    logic [31:0]       wbs_dat_i;
    logic              wbs_ack_o;
    logic [31:0]       wbs_dat_o;

    logic              io_req_i;
    logic              io_we_i;
    logic [ADDR_W-1:0] io_addr_i;
    logic [DATA_W-1:0] io_wdata_i;
    logic              io_gnt_o;
    logic              io_rvalid_o;
    logic [DATA_W-1:0] io_rdata_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        input  io_req_i, io_we_i, io_addr_i, io_wdata_i,
        output io_gnt_o, io_rvalid_o, io_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        output io_req_i, io_we_i, io_addr_i, io_wdata_i,
        input  io_gnt_o, io_rvalid_o, io_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_arb_ctrl.sv
// Two-requester (Wishbone / IO) arbiter in front of a synchronous single-port memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed WB priority.
module mem_arb_ctrl #(
    parameter int          ADDR_W  = 6,
    parameter int          DATA_W  = 8,
    parameter logic [31:0] WB_BASE = 32'h3000_0000
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    mem_arb_ctrl_if.slave bus,
    output logic          busy_o,
    output logic [1:0]    state_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              run_q;
    logic              owner_io_q;
    logic              we_q;
    logic              hit_q;
    logic              mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic wb_req, wb_hit, pick_io, start;
    logic unused_bits;

`ifdef MEM_ARB_RR_EN
    logic last_io_q;
`endif

    assign wb_req = bus.wbs_cyc_i & bus.wbs_stb_i;
    assign wb_hit = (bus.wbs_adr_i[31:8] == WB_BASE[31:8]);

`ifdef MEM_ARB_RR_EN
    // On contention the requester that was not served last wins.
    assign pick_io = bus.io_req_i & (~wb_req | ~last_io_q);
`else
    assign pick_io = bus.io_req_i & ~wb_req;
`endif

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_q && (wb_req || bus.io_req_i)) begin
                    state_d = ACCESS;
                    start   = 1'b1;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // run_q sets on the first edge after reset release, so arbitration starts on the second.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            owner_io_q  <= 1'b0;
            we_q        <= 1'b0;
            hit_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
`ifdef MEM_ARB_RR_EN
            last_io_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            run_q    <= 1'b1;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (start) begin
                owner_io_q <= pick_io;
`ifdef MEM_ARB_RR_EN
                last_io_q  <= pick_io;
`endif
                if (pick_io) begin
                    mem_en_q    <= 1'b1;
                    mem_we_q    <= bus.io_we_i;
                    mem_addr_q  <= bus.io_addr_i;
                    mem_wdata_q <= bus.io_wdata_i;
                    we_q        <= bus.io_we_i;
                    hit_q       <= 1'b1;
                end else begin
                    // A write with byte lane 0 disabled completes without touching memory.
                    mem_en_q    <= wb_hit & (~bus.wbs_we_i | bus.wbs_sel_i[0]);
                    mem_we_q    <= wb_hit & bus.wbs_we_i & bus.wbs_sel_i[0];
                    mem_addr_q  <= bus.wbs_adr_i[ADDR_W+1:2];
                    mem_wdata_q <= bus.wbs_dat_i[DATA_W-1:0];
                    we_q        <= bus.wbs_we_i;
                    hit_q       <= wb_hit;
                end
            end
            if (bus.io_rvalid_o)
                rdata_q <= bus.mem_rdata_i;
        end
    end

    assign bus.mem_en_o    = mem_en_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;

    // Responses are combinational in RESP so a master dropping cyc/stb kills the ack at once.
    assign bus.wbs_ack_o   = (state_q == RESP) & ~owner_io_q & wb_req;
    assign bus.wbs_dat_o   = (bus.wbs_ack_o & ~we_q & hit_q)
                             ? {{(32-DATA_W){1'b0}}, bus.mem_rdata_i} : 32'h0;
    assign bus.io_gnt_o    = (state_q == ACCESS) & owner_io_q;
    assign bus.io_rvalid_o = (state_q == RESP) & owner_io_q & ~we_q;
    assign bus.io_rdata_o  = bus.io_rvalid_o ? bus.mem_rdata_i : rdata_q;

    assign busy_o  = (state_q != IDLE);
    assign state_o = state_q;

    assign unused_bits = &{1'b0, bus.wbs_sel_i, bus.wbs_adr_i, bus.wbs_dat_i};
endmodule

// File: doc/mem_arb_ctrl.md
MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, memory word-address width (64 words).
REQ-002 SHALL have parameter DATA_W, default 8, memory word width.
REQ-003 SHALL have parameter WB_BASE, default 32'h3000_0000, Wishbone window base; decode compares wbs_adr_i[31:8] with WB_BASE[31:8].
REQ-004 SHALL have one clock and an asynchronous, active-low reset: wb_clk_i  in  1  clock (all logic rising-edge); wb_rst_ni  in  1  async active-low reset.
REQ-005 SHALL have Wishbone slave ports: wbs_cyc_i in 1; wbs_stb_i in 1; wbs_we_i in 1; wbs_sel_i in 4; wbs_adr_i in 32; wbs_dat_i in 32; wbs_ack_o out 1; wbs_dat_o out 32.
REQ-006 SHALL have IO requester ports: io_req_i in 1 request; io_we_i in 1 write; io_addr_i in ADDR_W; io_wdata_i in DATA_W; io_gnt_o out 1 request accepted; io_rvalid_o out 1 read data valid; io_rdata_o out DATA_W.
REQ-007 SHALL have memory ports: mem_en_o out 1; mem_we_o out 1; mem_addr_o out ADDR_W; mem_wdata_o out DATA_W; mem_rdata_i in DATA_W (synchronous read, data valid one cycle after mem_en_o).
REQ-008 SHALL have busy_o out 1, high whenever the FSM is not IDLE.

Function
REQ-009 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; owner register (WB/IO) captured on IDLE->ACCESS.
REQ-010 In IDLE, a WB request SHALL be wbs_cyc_i & wbs_stb_i; an IO request SHALL be io_req_i; no request keeps IDLE.
REQ-011 Request sampled in cycle N SHALL yield registered mem_en_o=1 in N+1 (ACCESS) with mem_we_o/mem_addr_o/mem_wdata_o from the captured request; mem_en_o SHALL be 1 for exactly one cycle per access.
REQ-012 WB access: mem_addr_o = wbs_adr_i[ADDR_W+1:2], mem_wdata_o = wbs_dat_i[7:0]; a write with wbs_sel_i[0]=0 SHALL drive mem_we_o=0, mem_en_o=0 (no memory change) but still complete.
REQ-013 WB access outside the decoded window SHALL not assert mem_en_o, SHALL complete with wbs_dat_o=0.
REQ-014 RESP (cycle N+2), owner WB: wbs_ack_o=1 for one cycle, only if wbs_cyc_i & wbs_stb_i still high; on read wbs_dat_o = {24'h0, mem_rdata_i}; otherwise wbs_dat_o=0.
REQ-015 Master dropping wbs_cyc_i during ACCESS/RESP SHALL abort the ack only; a started memory write still completes.
REQ-016 IO owner: io_gnt_o=1 for one cycle in ACCESS; on read io_rvalid_o=1 and io_rdata_o=mem_rdata_i for one cycle in RESP; io_rdata_o holds last value otherwise.
REQ-017 IO requester SHALL hold io_req_i and operands stable until io_gnt_o; io_req_i still high in the IDLE cycle after RESP SHALL be a new request.
REQ-018 Arbitration occurs only in IDLE; a request arriving during ACCESS/RESP waits; throughput one access per 3 cycles.
REQ-019 Write-then-read to the same address by any requesters SHALL return the written data.

Reset
REQ-020 On wb_rst_ni=0, asynchronously: FSM=IDLE, owner=WB, last-served=IO, and wbs_ack_o, wbs_dat_o, io_gnt_o, io_rvalid_o, io_rdata_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o all 0.
REQ-021 Reset mid-access SHALL discard the access with no ack/gnt/rvalid; memory written only if mem_en_o had already been sampled high.
REQ-022 Reset release SHALL be synchronised so the first arbitration occurs on the second rising edge after deassertion.

Configuration
REQ-023 With MEM_ARB_RR_EN defined: round-robin — on simultaneous requests in IDLE the requester not served last wins; last-served updates on each grant.
REQ-024 Without MEM_ARB_RR_EN: fixed priority, WB always wins simultaneous requests; last-served register absent.

Verification
REQ-025 WB write 0x3000_0014 data 0x0000_00A5 sel 4'b0001, then read -> mem write addr 5, ack at N+2 each, read wbs_dat_o=0x0000_00A5.
REQ-026 IO write addr 63 data 0x3C, IO read addr 63 -> io_gnt_o at N+1 each, io_rvalid_o at N+2 with io_rdata_o=0x3C.
REQ-027 WB and IO request same cycle repeatedly for 4 accesses -> RR build: WB,IO,WB,IO; non-RR: WB,WB,WB,WB while IO stalls.
REQ-028 WB read 0x4000_0000 -> no mem_en_o, ack at N+2, wbs_dat_o=0; WB write sel 4'b0010 -> ack, memory unchanged.
REQ-029 Assert wb_rst_ni=0 in ACCESS of an IO read -> all outputs 0 immediately, no io_rvalid_o; after release IO retry succeeds.
REQ-030 Drop wbs_cyc_i in ACCESS of a WB write of 0x77 to addr 2 -> no ack; subsequent read of addr 2 returns 0x77.
